// File: rtl/lamp_matrix_scan.sv
// -----------------------------------------------------------------------------
// lamp_matrix_scan
//
// Drives a 4x4 multiplexed lamp matrix from a 16-bit lamp pattern. One row is
// enabled at a time for SCAN_DIV clocks. Within each row dwell the column
// drivers are on for the first (bright+1)/4 of the dwell, giving 25/50/75/100 %
// duty. The pattern and brightness are captured when scanning starts and again
// at every frame end, so a mid-frame pattern change never tears the display.
//
// Parameters
//   SCAN_DIV   clocks per row dwell (multiple of 4, >= 4)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous reset, active-high
//   en         scan enable; low blanks the display and returns to idle
//   lamp_ctl   lamp pattern, bit 4*r+c = row r, column c
//   bright     brightness level 0..3
//   row_sel    one-hot row enable, active-high (0 = blank)
//   col_drv    column drive for the selected row, active-high
//   frame_done one-cycle pulse on the first cycle of every frame after the first
// -----------------------------------------------------------------------------
module lamp_matrix_scan #(
  parameter int SCAN_DIV = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] lamp_ctl,
  input  logic [1:0]  bright,
  output logic [3:0]  row_sel,
  output logic [3:0]  col_drv,
  output logic        frame_done
);

  localparam int DIV_W   = $clog2(SCAN_DIV);
  localparam int QUARTER = SCAN_DIV / 4;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       row_q, row_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [1:0]       bright_q, bright_d;
  logic             frame_done_d;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      row_q      <= '0;
      div_q      <= '0;
      shadow_q   <= '0;
      bright_q   <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      div_q      <= div_d;
      shadow_q   <= shadow_d;
      bright_q   <= bright_d;
      frame_done <= frame_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default before the case so that no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    div_d        = div_q;
    shadow_d     = shadow_q;
    bright_d     = bright_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        row_d = '0;
        div_d = '0;
        if (en) begin
          state_d  = SCAN;
          shadow_d = lamp_ctl;
          bright_d = bright;
        end
      end

      SCAN: begin
        if (!en) begin
          // Dropping enable wins over a coincident frame end: no snapshot,
          // no pulse. The shadow is kept but no longer displayed.
          state_d = IDLE;
          row_d   = '0;
          div_d   = '0;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          row_d = row_q + 2'd1;
          if (row_q == 2'd3) begin
            // Frame end: re-capture so the next frame is whole.
            shadow_d     = lamp_ctl;
            bright_d     = bright;
            frame_done_d = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (registers only, no input-to-output path)
  // ---------------------------------------------------------------------------
  // Number of leading dwell cycles with columns on; can equal SCAN_DIV, hence
  // one extra bit over the divider.
  logic [DIV_W:0] on_limit;

  always_comb begin
    unique case (bright_q)
      2'd0:    on_limit = (DIV_W+1)'(QUARTER);
      2'd1:    on_limit = (DIV_W+1)'(2 * QUARTER);
      2'd2:    on_limit = (DIV_W+1)'(3 * QUARTER);
      default: on_limit = (DIV_W+1)'(4 * QUARTER);
    endcase
  end

  always_comb begin
    row_sel = '0;
    col_drv = '0;
    if (state_q == SCAN) begin
      row_sel = 4'b0001 << row_q;
      if ({1'b0, div_q} < on_limit) begin
        col_drv = shadow_q[{row_q, 2'b00} +: 4];
      end
    end
  end

endmodule
